// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller owning the program counter.
//
// Sequences fetch_pc, issues requests to instruction memory and holds each
// request stable until acknowledged, and delivers fetched words to decode
// through a one-entry output register with backpressure. Redirects flush
// the output register; if a request is in flight the redirect waits for its
// acknowledge and the returned word is dropped.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   redirect_valid   one-cycle pulse: retarget fetch to redirect_target
//   redirect_target  new PC (low two bits ignored)
//   imem_req/addr    fetch request and address to instruction memory
//   imem_ack/rdata   request completion and instruction word
//   if_valid/pc/instr  output register towards decode
//   if_stall         decode backpressure
module fetch_ctrl #(
    parameter int unsigned              ADDRESS_WIDTH = 12,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    output logic                     if_valid,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [31:0]              if_instr,
    input  logic                     if_stall
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrop} state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] pend_target_q, pend_target_d;
    // Set while a FETCH-state request is waiting for its ack; keeps the
    // request up regardless of backpressure until it completes.
    logic                     req_out_q, req_out_d;
    logic                     if_valid_q, if_valid_d;
    logic [ADDRESS_WIDTH-1:0] if_pc_q, if_pc_d;
    logic [31:0]              if_instr_q, if_instr_d;

    logic                     slot_free;
    logic                     ack_acc;
    logic [ADDRESS_WIDTH-1:0] target;

    assign slot_free = !if_valid_q || !if_stall;
    assign ack_acc   = imem_req && imem_ack;
    assign target    = redirect_target & ~ADDRESS_WIDTH'(3);

    assign imem_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= RESET_PC;
            pend_target_q <= '0;
            req_out_q     <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= '0;
            if_instr_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_target_q <= pend_target_d;
            req_out_q     <= req_out_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_target_d = pend_target_q;
        req_out_d     = req_out_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;

        if (if_valid_q && !if_stall) begin
            if_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            if_valid_d = 1'b0;
            if (imem_req && !imem_ack) begin
                // Cannot abandon an in-flight request: wait for its ack.
                pend_target_d = target;
                state_d       = StDrop;
                req_out_d     = 1'b1;
            end else begin
                fetch_pc_d = target;
                state_d    = StFetch;
                req_out_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (ack_acc) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = fetch_pc_q;
                        if_instr_d = imem_rdata;
                        fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(4);
                        req_out_d  = 1'b0;
                    end else begin
                        req_out_d = imem_req;
                    end
                end
                StDrop: begin
                    if (ack_acc) begin
                        fetch_pc_d = pend_target_q;
                        state_d    = StFetch;
                        req_out_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        imem_req = 1'b0;
        unique case (state_q)
            StIdle:  imem_req = 1'b0;
            StFetch: imem_req = req_out_q || slot_free;
            StDrop:  imem_req = 1'b1;
            default: imem_req = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [11:0] redirect_target;
    logic        imem_ack;
    logic        if_stall;

    logic        req_a, req_b;
    logic [11:0] addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic        valid_a, valid_b;
    logic [11:0] pc_a, pc_b;
    logic [31:0] instr_a, instr_b;

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return 32'hC0DE_0000 ^ {20'h0, a} ^ {a, 20'h0};
    endfunction

    assign rdata_a = mem_word(addr_a);
    assign rdata_b = mem_word(addr_b);

    fetch_ctrl #(.ADDRESS_WIDTH(12), .RESET_PC(12'h000)) dut_a (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ack(imem_ack), .imem_rdata(rdata_a), .if_valid(valid_a), .if_pc(pc_a),
        .if_instr(instr_a), .if_stall(if_stall)
    );

    fetch_ctrl #(.ADDRESS_WIDTH(12), .RESET_PC(12'hFF8)) dut_b (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ack(imem_ack), .imem_rdata(rdata_b), .if_valid(valid_b), .if_pc(pc_b),
        .if_instr(instr_b), .if_stall(if_stall)
    );

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [11:0] tgt;
        logic        ack;
        logic        stall;
        logic        chk;
        logic        rst_state;
        logic        exp_req;
        logic [11:0] exp_addr;
        logic        exp_valid;
        logic [11:0] exp_pc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input logic [11:0] tgt,
                                input logic ack, input logic stall, input logic chk,
                                input logic rs, input logic er, input logic [11:0] ea,
                                input logic ev, input logic [11:0] ep);
        vec_t v;
        v.rst = r; v.rv = rv; v.tgt = tgt; v.ack = ack; v.stall = stall; v.chk = chk;
        v.rst_state = rs; v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    vec_t        vecs[$];
    logic [11:0] sb[$];

    initial begin
        int          delivered;
        logic [11:0] exp_a;
        logic [11:0] got_pc;

        //            rst rv tgt     ack st chk rs req addr    vld pc
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 0, 0, 0, 12'h000, 0, 12'h000));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 1, 1, 0, 12'h000, 0, 12'h000));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 0, 12'h000, 0, 12'h000));
        // zero-wait streaming
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h000, 0, 12'h000));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h004, 1, 12'h000));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h008, 1, 12'h004));
        // three wait states on 0x00C
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h00C, 1, 12'h008));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h00C, 0, 12'h008));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h00C, 0, 12'h008));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h00C, 0, 12'h008));
        // five-cycle stall: output frozen, no request
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 12'h000, 1, 1, 1, 0, 0, 12'h010, 1, 12'h00C));
        // release + redirect while 0x010 outstanding; ack two cycles later
        vecs.push_back(mk(0, 1, 12'h100, 0, 0, 1, 0, 1, 12'h010, 1, 12'h00C));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h010, 0, 12'h00C));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h010, 0, 12'h00C));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h100, 0, 12'h00C));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h104, 1, 12'h100));
        // redirect to 0x203 in the same cycle as ack of 0x108
        vecs.push_back(mk(0, 1, 12'h203, 1, 0, 1, 0, 1, 12'h108, 1, 12'h104));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h200, 0, 12'h104));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h204, 1, 12'h200));
        // reset during a wait-state request
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h208, 1, 12'h204));
        vecs.push_back(mk(1, 0, 12'h000, 0, 0, 1, 0, 1, 12'h208, 0, 12'h204));
        // redirect in IDLE
        vecs.push_back(mk(0, 1, 12'h040, 1, 0, 1, 1, 0, 12'h000, 0, 12'h000));
        vecs.push_back(mk(0, 0, 12'h000, 1, 0, 1, 0, 1, 12'h040, 0, 12'h000));
        // redirect while stalled with nothing outstanding
        vecs.push_back(mk(0, 1, 12'h300, 0, 1, 1, 0, 0, 12'h044, 1, 12'h040));
        vecs.push_back(mk(0, 0, 12'h000, 1, 1, 1, 0, 1, 12'h300, 0, 12'h040));
        vecs.push_back(mk(0, 0, 12'h000, 0, 0, 1, 0, 1, 12'h304, 1, 12'h300));

        foreach (vecs[i]) begin
            rst             = vecs[i].rst;
            redirect_valid  = vecs[i].rv;
            redirect_target = vecs[i].tgt;
            imem_ack        = vecs[i].ack;
            if_stall        = vecs[i].stall;
            @(negedge clk);
            if (vecs[i].chk) begin
                check("imem_req", i, 32'(req_a), 32'(vecs[i].exp_req));
                check("imem_addr", i, 32'(addr_a), 32'(vecs[i].exp_addr));
                check("if_valid", i, 32'(valid_a), 32'(vecs[i].exp_valid));
                check("if_pc", i, 32'(pc_a), 32'(vecs[i].exp_pc));
                if (vecs[i].exp_valid)
                    check("if_instr", i, instr_a, mem_word(vecs[i].exp_pc));
                if (vecs[i].rst_state)
                    check("if_instr_rst", i, instr_a, 32'h0);
            end
            @(posedge clk);
            #1;
        end

        // Wrap-around from RESET_PC=0xFF8 with zero-wait memory.
        rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
        imem_ack = 1'b1; if_stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("wrap_idle_req", 0, 32'(req_b), 32'h0);
        @(posedge clk); #1;
        delivered = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (valid_b) begin
                if (sb.size() == 0) begin
                    nchecks++; nerrors++;
                    $display("FAIL wrap_extra [%0d]: got pc %h, expected none", k, pc_b);
                end else begin
                    got_pc = sb.pop_front();
                    check("wrap_pc", k, 32'(pc_b), 32'(got_pc));
                    check("wrap_instr", k, instr_b, mem_word(got_pc));
                    delivered++;
                end
            end
            if (k < 4) begin
                exp_a = 12'hFF8 + 12'(4 * k);
                check("wrap_req", k, 32'(req_b), 32'h1);
                check("wrap_addr", k, 32'(addr_b), 32'(exp_a));
                sb.push_back(exp_a);
            end
            @(posedge clk); #1;
        end
        check("wrap_delivered", 0, 32'(delivered), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
